// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind the execute-stage memory port.
// Lane-masked byte/half/word stores, sign/zero-extended loads, optional wait states.
`default_nettype none

module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_dat_in,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] rd_dat_out,
  output logic        rd_valid,
  output logic        busy,
  output logic        misalign_err
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        req, reject, accept, exec, capture, ram_we;

  logic [AW+1:0] cap_addr;
  logic [31:0]   cap_dat;
  logic          cap_wr, cap_uns;
  logic [1:0]    cap_size;

  logic [AW+1:0] op_addr;
  logic [31:0]   op_dat;
  logic          op_wr, op_uns;
  logic [1:0]    op_size;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] word_rd, shifted, load_val, wdata;
  logic [3:0]  be;

  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr_in[31:AW+2];

  assign req    = (state == IDLE) && (mem_read_en || mem_write_en);
  assign reject = req && ((mem_read_en && mem_write_en) ||
                          (mem_size == 2'b11) ||
                          (mem_size == 2'b01 && mem_addr_in[0]) ||
                          (mem_size == 2'b10 && mem_addr_in[1:0] != 2'b00));
  assign accept = req && !reject;
  assign busy   = (state == WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    exec     = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (NO_WAIT) begin
            exec = 1'b1;
          end else begin
            capture  = 1'b1;
            state_nx = WAIT;
            cnt_nx   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          exec     = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Zero-wait ops execute straight from the port; delayed ops use the captured copy.
  always_comb begin
    if (state == IDLE) begin
      op_addr = mem_addr_in[AW+1:0];
      op_dat  = mem_dat_in;
      op_wr   = mem_write_en;
      op_uns  = mem_unsigned;
      op_size = mem_size;
    end else begin
      op_addr = cap_addr;
      op_dat  = cap_dat;
      op_wr   = cap_wr;
      op_uns  = cap_uns;
      op_size = cap_size;
    end
  end

  assign idx = op_addr[AW+1:2];

  always_comb begin
    be    = 4'b1111;
    wdata = op_dat;
    case (op_size)
      2'b00: begin
        be    = 4'b0001 << op_addr[1:0];
        wdata = {4{op_dat[7:0]}};
      end
      2'b01: begin
        be    = op_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{op_dat[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    word_rd = mem[idx];
    shifted = word_rd >> {op_addr[1:0], 3'b000};
    case (op_size)
      2'b00:   load_val = op_uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = op_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = word_rd;
    endcase
  end

  // rst_n gate keeps a zero-wait request presented during reset from landing in RAM.
  assign ram_we = exec && op_wr && rst_n;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dat_out   <= 32'd0;
      rd_valid     <= 1'b0;
      misalign_err <= 1'b0;
      cap_addr     <= '0;
      cap_dat      <= 32'd0;
      cap_wr       <= 1'b0;
      cap_uns      <= 1'b0;
      cap_size     <= 2'b00;
    end else begin
      rd_valid     <= exec && !op_wr;
      misalign_err <= reject;
      if (exec && !op_wr) rd_dat_out <= load_val;
      if (capture) begin
        cap_addr <= mem_addr_in[AW+1:0];
        cap_dat  <= mem_dat_in;
        cap_wr   <= mem_write_en;
        cap_uns  <= mem_unsigned;
        cap_size <= mem_size;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder with zero and three wait states.
`default_nettype none

module tb_dmem_responder;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } ev_t;

  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

  logic        clk = 1'b0;
  logic [1:0]  rst_n;
  logic [31:0] addr [2];
  logic [31:0] dat  [2];
  logic [1:0]  re, we, uns;
  logic [1:0]  sz   [2];
  logic [31:0] rdat [2];
  logic [1:0]  rv, bsy, err;

  ev_t q0[$];
  ev_t q1[$];
  int  checks   = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) d0 (
    .clk(clk), .rst_n(rst_n[0]), .mem_addr_in(addr[0]), .mem_dat_in(dat[0]),
    .mem_read_en(re[0]), .mem_write_en(we[0]), .mem_size(sz[0]), .mem_unsigned(uns[0]),
    .rd_dat_out(rdat[0]), .rd_valid(rv[0]), .busy(bsy[0]), .misalign_err(err[0]));

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) d3 (
    .clk(clk), .rst_n(rst_n[1]), .mem_addr_in(addr[1]), .mem_dat_in(dat[1]),
    .mem_read_en(re[1]), .mem_write_en(we[1]), .mem_size(sz[1]), .mem_unsigned(uns[1]),
    .rd_dat_out(rdat[1]), .rd_valid(rv[1]), .busy(bsy[1]), .misalign_err(err[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic e, input logic [31:0] d);
    ev_t ev;
    ev.err = e;
    ev.dat = d;
    if (k == 0) q0.push_back(ev);
    else        q1.push_back(ev);
  endtask

  // Monitor: every response pulse is matched against the next queued expectation.
  task automatic mon(input int k);
    ev_t ev;
    bit  empty;
    if (rv[k] || err[k]) begin
      empty = 1'b0;
      ev    = '0;
      if (k == 0) begin
        if (q0.size() == 0) empty = 1'b1; else ev = q0.pop_front();
      end else begin
        if (q1.size() == 0) empty = 1'b1; else ev = q1.pop_front();
      end
      checks++;
      if (empty) begin
        failures++;
        $display("FAIL unexpected_resp dut%0d: rd_valid=%0b misalign_err=%0b data=0x%08h, none expected",
                 k, rv[k], err[k], rdat[k]);
      end else if (ev.err) begin
        if (!(err[k] && !rv[k])) begin
          failures++;
          $display("FAIL reject dut%0d: rd_valid=%0b misalign_err=%0b, required misalign_err only",
                   k, rv[k], err[k]);
        end
      end else if (!(rv[k] && !err[k] && rdat[k] === ev.dat)) begin
        failures++;
        $display("FAIL load dut%0d: rd_valid=%0b err=%0b data=0x%08h, required 0x%08h",
                 k, rv[k], err[k], rdat[k], ev.dat);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic wait_idle(input int k);
    int n = 0;
    while (bsy[k] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (bsy[k]) chk("busy_timeout", 32'(bsy[k]), 32'd0);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge ending the access.
  task automatic req(input int k, input logic rd, input logic wr, input logic [1:0] s,
                     input logic u, input logic [31:0] a, input logic [31:0] d,
                     input logic exp_err, input logic [31:0] exp_dat);
    if (exp_err) push(k, 1'b1, 32'd0);
    else if (rd) push(k, 1'b0, exp_dat);
    re[k] = rd; we[k] = wr; sz[k] = s; uns[k] = u; addr[k] = a; dat[k] = d;
    @(posedge clk); #1;
    re[k] = 1'b0; we[k] = 1'b0;
    wait_idle(k);
  endtask

  task automatic st(input int k, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    req(k, 1'b0, 1'b1, s, 1'b0, a, d, 1'b0, 32'd0);
  endtask

  task automatic ld(input int k, input logic [1:0] s, input logic u, input logic [31:0] a,
                    input logic [31:0] e);
    req(k, 1'b1, 1'b0, s, u, a, 32'd0, 1'b0, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 2'b00; re = 2'b00; we = 2'b00; uns = 2'b00;
    for (int k = 0; k < 2; k++) begin
      addr[k] = 32'd0; dat[k] = 32'd0; sz[k] = SW;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_rd_dat", rdat[k], 32'd0);
      chk("reset_flags", {29'd0, rv[k], bsy[k], err[k]}, 32'd0);
    end
    rst_n = 2'b11;
    @(posedge clk); #1;

    // Zero wait states: back-to-back store then load.
    st(0, SW, 32'h10, 32'hDEADBEEF);
    chk("n0_busy_after_store", 32'(bsy[0]), 32'd0);
    ld(0, SW, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("n0_busy_after_load", 32'(bsy[0]), 32'd0);

    st(0, SB, 32'h13, 32'h00000080);
    ld(0, SB, 1'b0, 32'h13, 32'hFFFFFF80);
    ld(0, SB, 1'b1, 32'h13, 32'h00000080);
    ld(0, SW, 1'b0, 32'h10, 32'h80ADBEEF);

    req(0, 1'b0, 1'b1, SH, 1'b0, 32'h11, 32'h0000FFFF, 1'b1, 32'd0);
    chk("reject_no_busy", 32'(bsy[0]), 32'd0);
    ld(0, SW, 1'b0, 32'h10, 32'h80ADBEEF);
    req(0, 1'b1, 1'b1, SW, 1'b0, 32'h10, 32'h0, 1'b1, 32'd0);
    req(0, 1'b1, 1'b0, SX, 1'b0, 32'h10, 32'h0, 1'b1, 32'd0);
    req(0, 1'b0, 1'b1, SW, 1'b0, 32'h12, 32'h0, 1'b1, 32'd0);
    ld(0, SW, 1'b0, 32'h10, 32'h80ADBEEF);

    st(0, SH, 32'h12, 32'h00001234);
    ld(0, SW, 1'b0, 32'h10, 32'h1234BEEF);
    st(0, SB, 32'h11, 32'hFFFFFF55);
    ld(0, SB, 1'b1, 32'h11, 32'h00000055);
    ld(0, SW, 1'b0, 32'h10, 32'h123455EF);

    st(0, SW, 32'h20, 32'h80017FFF);
    ld(0, SH, 1'b0, 32'h22, 32'hFFFF8001);
    ld(0, SH, 1'b1, 32'h22, 32'h00008001);
    ld(0, SH, 1'b0, 32'h20, 32'h00007FFF);
    st(0, SW, 32'h1000, 32'hA5A5A5A5);
    ld(0, SW, 1'b0, 32'h0, 32'hA5A5A5A5);

    // Three wait states.
    st(1, SW, 32'h44, 32'h11111111);
    st(1, SW, 32'h08, 32'hCAFEF00D);
    push(1, 1'b0, 32'hCAFEF00D);
    re[1] = 1'b1; sz[1] = SW; addr[1] = 32'h08; uns[1] = 1'b0;
    @(posedge clk); #1;
    re[1] = 1'b0; we[1] = 1'b1; addr[1] = 32'h44; dat[1] = 32'hFFFFFFFF;
    for (int c = 1; c <= 3; c++) begin
      chk("n3_busy_window", 32'(bsy[1]), 32'd1);
      if (c == 2) we[1] = 1'b0;
      @(posedge clk); #1;
    end
    chk("n3_busy_release", 32'(bsy[1]), 32'd0);
    ld(1, SW, 1'b0, 32'h44, 32'h11111111);

    st(1, SW, 32'h20, 32'h00000000);
    we[1] = 1'b1; sz[1] = SW; addr[1] = 32'h20; dat[1] = 32'h12345678;
    @(posedge clk); #1;
    we[1] = 1'b0;
    chk("n3_busy_before_reset", 32'(bsy[1]), 32'd1);
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    #1;
    chk("midreset_rd_dat", rdat[1], 32'd0);
    chk("midreset_flags", {29'd0, rv[1], bsy[1], err[1]}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    ld(1, SW, 1'b0, 32'h20, 32'h00000000);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
